// File: rtl/alu_step_sequencer_pkg.sv
// Shared encodings for the ALU control-step sequencer: instruction field
// positions, opcode values, opcode classes and the FSM state enum.
package alu_step_sequencer_pkg;

   localparam int OPC_LSB = 27;
   localparam int RA_LSB  = 23;
   localparam int RB_LSB  = 19;
   localparam int RC_LSB  = 15;
   localparam int FLD_OPC_W = 5;
   localparam int IDX_W   = 4;

   localparam logic [FLD_OPC_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [FLD_OPC_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [FLD_OPC_W-1:0] OP_AND  = 5'b00101;
   localparam logic [FLD_OPC_W-1:0] OP_OR   = 5'b00110;
   localparam logic [FLD_OPC_W-1:0] OP_SHR  = 5'b00111;
   localparam logic [FLD_OPC_W-1:0] OP_SHRA = 5'b01000;
   localparam logic [FLD_OPC_W-1:0] OP_SHL  = 5'b01001;
   localparam logic [FLD_OPC_W-1:0] OP_ROR  = 5'b01010;
   localparam logic [FLD_OPC_W-1:0] OP_ROL  = 5'b01011;
   localparam logic [FLD_OPC_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [FLD_OPC_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [FLD_OPC_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [FLD_OPC_W-1:0] OP_NOT  = 5'b10010;

   typedef enum logic [1:0] {
      CLS_ILL,
      CLS_UN,
      CLS_BIN,
      CLS_MD
   } op_class_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_DONE
   } state_e;

   function automatic op_class_e classify(input logic [FLD_OPC_W-1:0] opc);
      op_class_e cls;
      case (opc)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL: cls = CLS_BIN;
         OP_MUL, OP_DIV:                  cls = CLS_MD;
         OP_NEG, OP_NOT:                  cls = CLS_UN;
         default:                         cls = CLS_ILL;
      endcase
      return cls;
   endfunction

   function automatic logic reg_ok(input logic [IDX_W-1:0] idx, input int nregs);
      return int'(idx) < nregs;
   endfunction

endpackage

// File: rtl/alu_step_sequencer_onehot_decoder.sv
// Register index to one-hot select; all zeros when disabled or when the
// index does not name an existing register.
module alu_step_sequencer_onehot_decoder #(
   parameter int N     = 16,
   parameter int IDX_W = 4
) (
   input  logic             en_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic [N-1:0]     onehot_o
);

   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < N; i++) begin
         if (en_i && (idx_i == IDX_W'(i))) onehot_o[i] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_step_sequencer.sv
// Fetch/decode/execute control-step generator: one instruction per start
// pulse, Moore strobes decoded from the state register and latched fields.
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC to MAR, increment PC
// T1    | memory read, held until mem_ready (bounded by MEM_TIMEOUT)
// T2    | MDR to IR
// T3    | decode live IR, first operand step; fields latched here
// T4    | UN writeback / BIN, MD second operand + ALU
// T5    | BIN writeback / MD low result
// T6    | MD high result
// DONE  | one-cycle completion pulse
module alu_step_sequencer
   import alu_step_sequencer_pkg::*;
#(
   parameter int NUM_REGS    = 16,
   parameter int DATA_W      = 32,
   parameter int OPCODE_W    = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clock_i,
   input  logic                clear_i,
   input  logic                start_i,
   input  logic [DATA_W-1:0]   ir_i,
   input  logic                mem_ready_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                illegal_o,
   output logic                timeout_o,
   output logic                pc_out_o,
   output logic                mar_in_o,
   output logic                inc_pc_o,
   output logic                pc_in_o,
   output logic                read_o,
   output logic                mdr_in_o,
   output logic                mdr_out_o,
   output logic                ir_in_o,
   output logic                y_in_o,
   output logic                z_low_in_o,
   output logic                z_high_in_o,
   output logic                z_low_out_o,
   output logic                z_high_out_o,
   output logic                hi_in_o,
   output logic                lo_in_o,
   output logic [OPCODE_W-1:0] alu_op_o,
   output logic [NUM_REGS-1:0] reg_out_o,
   output logic [NUM_REGS-1:0] reg_in_o
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_e                 state_q;
   op_class_e              cls_q;
   logic [FLD_OPC_W-1:0]   opc_q;
   logic [IDX_W-1:0]       ra_q;
   logic [IDX_W-1:0]       rc_q;
   logic [CNT_W-1:0]       wait_q;
   logic                   illegal_q;
   logic                   timeout_q;

   logic [FLD_OPC_W-1:0]   ir_opc;
   logic [IDX_W-1:0]       ir_ra;
   logic [IDX_W-1:0]       ir_rb;
   logic [IDX_W-1:0]       ir_rc;
   op_class_e              ir_cls;
   logic                   ir_bad;
   logic [DATA_W-1:0]      unused_ir;

   assign ir_opc    = ir_i[OPC_LSB +: FLD_OPC_W];
   assign ir_ra     = ir_i[RA_LSB +: IDX_W];
   assign ir_rb     = ir_i[RB_LSB +: IDX_W];
   assign ir_rc     = ir_i[RC_LSB +: IDX_W];
   assign ir_cls    = classify(ir_opc);
   assign unused_ir = ir_i;

   // Only the register fields an instruction class actually uses are range-checked.
   always_comb begin
      ir_bad = 1'b1;
      case (ir_cls)
         CLS_UN:  ir_bad = !(reg_ok(ir_ra, NUM_REGS) && reg_ok(ir_rb, NUM_REGS));
         CLS_BIN: ir_bad = !(reg_ok(ir_ra, NUM_REGS) && reg_ok(ir_rb, NUM_REGS)
                             && reg_ok(ir_rc, NUM_REGS));
         CLS_MD:  ir_bad = !(reg_ok(ir_rb, NUM_REGS) && reg_ok(ir_rc, NUM_REGS));
         default: ir_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (clear_i) begin
         state_q   <= ST_IDLE;
         cls_q     <= CLS_ILL;
         opc_q     <= '0;
         ra_q      <= '0;
         rc_q      <= '0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_q   <= ST_T0;
                  illegal_q <= 1'b0;
                  timeout_q <= 1'b0;
               end
            end
            ST_T0: begin
               state_q <= ST_T1;
               wait_q  <= '0;
            end
            ST_T1: begin
               if (mem_ready_i) begin
                  state_q <= ST_T2;
               end else if (wait_q == WAIT_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  wait_q <= wait_q + CNT_W'(1);
               end
            end
            ST_T2: state_q <= ST_T3;
            ST_T3: begin
               if (ir_bad) begin
                  illegal_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  cls_q   <= ir_cls;
                  opc_q   <= ir_opc;
                  ra_q    <= ir_ra;
                  rc_q    <= ir_rc;
                  state_q <= ST_T4;
               end
            end
            ST_T4:   state_q <= (cls_q == CLS_UN) ? ST_DONE : ST_T5;
            ST_T5:   state_q <= (cls_q == CLS_BIN) ? ST_DONE : ST_T6;
            ST_T6:   state_q <= ST_DONE;
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   logic             ro_en;
   logic             ri_en;
   logic [IDX_W-1:0] ro_idx;
   logic [IDX_W-1:0] ri_idx;

   always_comb begin
      pc_out_o     = 1'b0;
      mar_in_o     = 1'b0;
      inc_pc_o     = 1'b0;
      pc_in_o      = 1'b0;
      read_o       = 1'b0;
      mdr_in_o     = 1'b0;
      mdr_out_o    = 1'b0;
      ir_in_o      = 1'b0;
      y_in_o       = 1'b0;
      z_low_in_o   = 1'b0;
      z_high_in_o  = 1'b0;
      z_low_out_o  = 1'b0;
      z_high_out_o = 1'b0;
      hi_in_o      = 1'b0;
      lo_in_o      = 1'b0;
      alu_op_o     = '0;
      ro_en        = 1'b0;
      ri_en        = 1'b0;
      ro_idx       = '0;
      ri_idx       = '0;
      case (state_q)
         ST_T0: begin
            pc_out_o   = 1'b1;
            mar_in_o   = 1'b1;
            inc_pc_o   = 1'b1;
            z_low_in_o = 1'b1;
         end
         ST_T1: begin
            z_low_out_o = 1'b1;
            pc_in_o     = (wait_q == '0);
            read_o      = 1'b1;
            mdr_in_o    = 1'b1;
         end
         ST_T2: begin
            mdr_out_o = 1'b1;
            ir_in_o   = 1'b1;
         end
         ST_T3: begin
            if (!ir_bad) begin
               ro_en  = 1'b1;
               ro_idx = ir_rb;
               if (ir_cls == CLS_UN) begin
                  alu_op_o   = OPCODE_W'(ir_opc);
                  z_low_in_o = 1'b1;
               end else begin
                  y_in_o = 1'b1;
               end
            end
         end
         ST_T4: begin
            if (cls_q == CLS_UN) begin
               z_low_out_o = 1'b1;
               ri_en       = 1'b1;
               ri_idx      = ra_q;
            end else begin
               ro_en       = 1'b1;
               ro_idx      = rc_q;
               alu_op_o    = OPCODE_W'(opc_q);
               z_low_in_o  = 1'b1;
               z_high_in_o = (cls_q == CLS_MD);
            end
         end
         ST_T5: begin
            z_low_out_o = 1'b1;
            if (cls_q == CLS_BIN) begin
               ri_en  = 1'b1;
               ri_idx = ra_q;
            end else begin
               lo_in_o = 1'b1;
            end
         end
         ST_T6: begin
            z_high_out_o = 1'b1;
            hi_in_o      = 1'b1;
         end
         default: ;
      endcase
   end

   alu_step_sequencer_onehot_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_reg_out_dec (
      .en_i     (ro_en),
      .idx_i    (ro_idx),
      .onehot_o (reg_out_o)
   );

   alu_step_sequencer_onehot_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_reg_in_dec (
      .en_i     (ri_en),
      .idx_i    (ri_idx),
      .onehot_o (reg_in_o)
   );

   assign busy_o    = (state_q != ST_IDLE);
   assign done_o    = (state_q == ST_DONE);
   assign illegal_o = illegal_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer: per-cycle history of the strobes is
// captured for each instruction and compared against hand-derived values.
module tb_alu_step_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic        mem_ready;
   logic [31:0] ir;

   logic busy, done, illegal, timeout;
   logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
   logic y_in, z_low_in, z_high_in, z_low_out, z_high_out, hi_in, lo_in;
   logic [4:0]  alu_op;
   logic [15:0] reg_out, reg_in;

   logic busy_8, done_8, illegal_8, timeout_8;
   logic pc_out_8, mar_in_8, inc_pc_8, pc_in_8, read_8, mdr_in_8, mdr_out_8, ir_in_8;
   logic y_in_8, z_low_in_8, z_high_in_8, z_low_out_8, z_high_out_8, hi_in_8, lo_in_8;
   logic [4:0] alu_op_8;
   logic [7:0] reg_out_8, reg_in_8;

   always #5 clock = ~clock;

   alu_step_sequencer dut (
      .clock_i(clock), .clear_i(clear), .start_i(start), .ir_i(ir), .mem_ready_i(mem_ready),
      .busy_o(busy), .done_o(done), .illegal_o(illegal), .timeout_o(timeout),
      .pc_out_o(pc_out), .mar_in_o(mar_in), .inc_pc_o(inc_pc), .pc_in_o(pc_in),
      .read_o(read), .mdr_in_o(mdr_in), .mdr_out_o(mdr_out), .ir_in_o(ir_in),
      .y_in_o(y_in), .z_low_in_o(z_low_in), .z_high_in_o(z_high_in),
      .z_low_out_o(z_low_out), .z_high_out_o(z_high_out), .hi_in_o(hi_in), .lo_in_o(lo_in),
      .alu_op_o(alu_op), .reg_out_o(reg_out), .reg_in_o(reg_in)
   );

   alu_step_sequencer #(.NUM_REGS(8)) dut8 (
      .clock_i(clock), .clear_i(clear), .start_i(start), .ir_i(ir), .mem_ready_i(mem_ready),
      .busy_o(busy_8), .done_o(done_8), .illegal_o(illegal_8), .timeout_o(timeout_8),
      .pc_out_o(pc_out_8), .mar_in_o(mar_in_8), .inc_pc_o(inc_pc_8), .pc_in_o(pc_in_8),
      .read_o(read_8), .mdr_in_o(mdr_in_8), .mdr_out_o(mdr_out_8), .ir_in_o(ir_in_8),
      .y_in_o(y_in_8), .z_low_in_o(z_low_in_8), .z_high_in_o(z_high_in_8),
      .z_low_out_o(z_low_out_8), .z_high_out_o(z_high_out_8), .hi_in_o(hi_in_8), .lo_in_o(lo_in_8),
      .alu_op_o(alu_op_8), .reg_out_o(reg_out_8), .reg_in_o(reg_in_8)
   );

   // Bit order: pc_out mar_in inc_pc pc_in read mdr_in mdr_out ir_in
   //            y_in z_low_in z_high_in z_low_out z_high_out hi_in lo_in
   logic [14:0] stb;
   assign stb = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
                 y_in, z_low_in, z_high_in, z_low_out, z_high_out, hi_in, lo_in};

   localparam int B_PC_IN  = 11;
   localparam int B_READ   = 10;
   localparam int B_MDR_IN = 9;

   localparam logic [14:0] STB_T0   = 15'h7020;
   localparam logic [14:0] STB_T1F  = 15'h0E08;
   localparam logic [14:0] STB_T2   = 15'h0180;
   localparam logic [14:0] STB_ZLI  = 15'h0020;
   localparam logic [14:0] STB_ZLO  = 15'h0008;
   localparam logic [14:0] STB_YIN  = 15'h0040;
   localparam logic [14:0] STB_MD4  = 15'h0030;
   localparam logic [14:0] STB_MD5  = 15'h0009;
   localparam logic [14:0] STB_MD6  = 15'h0006;

   logic [14:0] stb_h  [0:47];
   logic [15:0] ro_h   [0:47];
   logic [15:0] ri_h   [0:47];
   logic [4:0]  op_h   [0:47];
   logic        busy_h [0:47];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc);
      return {opc, ra, rb, rc, 15'd0};
   endfunction

   function automatic int cnt_bit(input int b, input int n);
      int s = 0;
      for (int c = 1; c <= n; c++) if (stb_h[c][b]) s++;
      return s;
   endfunction

   function automatic logic [15:0] ri_any(input int n);
      logic [15:0] acc = '0;
      for (int c = 1; c <= n; c++) acc |= ri_h[c];
      return acc;
   endfunction

   // Cycle 1 is the T0 cycle; mem_ready is held low for the first 'stall'
   // T1 cycles, and start is re-pulsed in cycle start_at (0 = never).
   task automatic run(input logic [31:0] instr, input int stall, input int start_at,
                      input int ncyc, output int done_cyc, output int done_cnt);
      done_cyc = 0;
      done_cnt = 0;
      ir    = instr;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         mem_ready = !(c >= 2 && c < 2 + stall);
         start     = (c == start_at);
         stb_h[c]  = stb;
         ro_h[c]   = reg_out;
         ri_h[c]   = reg_in;
         op_h[c]   = alu_op;
         busy_h[c] = busy;
         if (done) begin
            if (done_cyc == 0) done_cyc = c;
            done_cnt++;
         end
         tick();
      end
      start     = 1'b0;
      mem_ready = 1'b1;
   endtask

   initial begin
      int dc, dn;
      clear = 1'b1;
      start = 1'b0;
      mem_ready = 1'b1;
      ir = '0;
      tick();
      tick();
      clear = 1'b0;

      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_strobes", stb, 0);
      chk("rst_regs", {reg_out, reg_in}, 0);
      chk("rst_aluop", alu_op, 0);

      // NEG r1 <- r6, with a start pulse in T2 that must be ignored
      run(mk(5'b10001, 4'd1, 4'd6, 4'd0), 0, 3, 10, dc, dn);
      chk("neg_t0_stb", stb_h[1], STB_T0);
      chk("neg_t1_stb", stb_h[2], STB_T1F);
      chk("neg_t2_stb", stb_h[3], STB_T2);
      chk("neg_t3_regout", ro_h[4], 16'h0040);
      chk("neg_t3_aluop", op_h[4], 5'b10001);
      chk("neg_t3_stb", stb_h[4], STB_ZLI);
      chk("neg_t4_regin", ri_h[5], 16'h0002);
      chk("neg_t4_stb", stb_h[5], STB_ZLO);
      chk("neg_done_cycle", dc, 6);
      chk("neg_done_count", dn, 1);
      chk("neg_idle_after", busy_h[7], 0);

      // ADD r2 <- r6 + r7
      run(mk(5'b00011, 4'd2, 4'd6, 4'd7), 0, 0, 10, dc, dn);
      chk("add_t3_regout", ro_h[4], 16'h0040);
      chk("add_t3_stb", stb_h[4], STB_YIN);
      chk("add_t3_aluop", op_h[4], 0);
      chk("add_t4_regout", ro_h[5], 16'h0080);
      chk("add_t4_aluop", op_h[5], 5'b00011);
      chk("add_t4_stb", stb_h[5], STB_ZLI);
      chk("add_t5_regin", ri_h[6], 16'h0004);
      chk("add_t5_stb", stb_h[6], STB_ZLO);
      chk("add_done_cycle", dc, 7);

      // MUL r3 * r4 into HI/LO
      run(mk(5'b01111, 4'd0, 4'd3, 4'd4), 0, 0, 11, dc, dn);
      chk("mul_t3_regout", ro_h[4], 16'h0008);
      chk("mul_t4_regout", ro_h[5], 16'h0010);
      chk("mul_t4_stb", stb_h[5], STB_MD4);
      chk("mul_t5_stb", stb_h[6], STB_MD5);
      chk("mul_t6_stb", stb_h[7], STB_MD6);
      chk("mul_regin_never", ri_any(11), 0);
      chk("mul_done_cycle", dc, 8);

      // three memory stall cycles
      run(mk(5'b00011, 4'd2, 4'd6, 4'd7), 3, 0, 14, dc, dn);
      chk("stall3_read_cycles", cnt_bit(B_READ, 14), 4);
      chk("stall3_mdrin_cycles", cnt_bit(B_MDR_IN, 14), 4);
      chk("stall3_pcin_cycles", cnt_bit(B_PC_IN, 14), 1);
      chk("stall3_done_cycle", dc, 10);

      // one short of the timeout still completes
      run(mk(5'b00011, 4'd2, 4'd6, 4'd7), 14, 0, 25, dc, dn);
      chk("stall14_done_cycle", dc, 21);
      chk("stall14_timeout", timeout, 0);

      // timeout abort
      run(mk(5'b00011, 4'd2, 4'd6, 4'd7), 15, 0, 20, dc, dn);
      chk("tmo_flag", timeout, 1);
      chk("tmo_no_done", dn, 0);
      chk("tmo_read_cycles", cnt_bit(B_READ, 20), 15);
      chk("tmo_idle", busy_h[17], 0);

      // illegal opcode; also clears the previous timeout
      run(mk(5'b11111, 4'd1, 4'd2, 4'd3), 0, 0, 10, dc, dn);
      chk("ill_timeout_cleared", timeout, 0);
      chk("ill_flag", illegal, 1);
      chk("ill_t3_stb", stb_h[4], 0);
      chk("ill_t3_regout", ro_h[4], 0);
      chk("ill_regin_never", ri_any(10), 0);
      chk("ill_no_done", dn, 0);
      chk("ill_idle", busy_h[5], 0);

      // a good instruction clears illegal on both instances
      run(mk(5'b10010, 4'd3, 4'd5, 4'd0), 0, 0, 10, dc, dn);
      chk("ok_illegal_cleared", illegal, 0);
      chk("ok8_illegal_cleared", illegal_8, 0);
      chk("not_done_cycle", dc, 6);

      // rb=9 is out of range only for the 8-register instance
      run(mk(5'b00011, 4'd1, 4'd9, 4'd2), 0, 0, 10, dc, dn);
      chk("rb9_illegal_n8", illegal_8, 1);
      chk("rb9_illegal_n16", illegal, 0);
      chk("rb9_done_n16", dc, 7);

      // clear during T4 of ADD
      ir = mk(5'b00011, 4'd2, 4'd6, 4'd7);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("clr_in_t4", reg_out, 16'h0080);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_busy", busy, 0);
      chk("clr_strobes", stb, 0);
      chk("clr_regs", {reg_out, reg_in}, 0);
      chk("clr_aluop", alu_op, 0);
      dn = 0;
      for (int k = 0; k < 8; k++) begin
         if (done || busy) dn++;
         tick();
      end
      chk("clr_stays_idle", dn, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
